// File: rtl/key_filter_pulse_pkg.sv
// Shared types and constants for the key debounce / press-pulse block.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_FLT = 2'd1,
      DOWN      = 2'd2,
      REL_FLT   = 2'd3
   } key_state_e;

   localparam int unsigned CNT_MAX_DEF = 32'd1_000_000;

   // Filter counter width; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_cnt);
      int unsigned w;
      w = $clog2(max_cnt);
      if (w < 32'd1) begin
         w = 32'd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/key_filter_pulse_if.sv
// Key pin and debounced outputs of one key_filter_pulse instance.
interface key_filter_pulse_if;
   logic key_in;
   logic key_pulse;
   logic key_state;
   logic key_release;

   modport master (output key_in, input key_pulse, input key_state, input key_release);
   modport slave  (input key_in, output key_pulse, output key_state, output key_release);
endinterface

// File: rtl/key_filter_pulse_sync_2ff.sv
// One-bit two-stage synchroniser for asynchronous pin inputs, reset to RST_VAL.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two flops in series; the reset level keeps the downstream logic quiet after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/key_filter_pulse.sv
// Key debouncer emitting one key_pulse per accepted press.
// Optional feature macro KEY_RELEASE_EN enables the one-cycle key_release output.
module key_filter_pulse
   import key_pkg::*;
#(
   parameter int unsigned CNT_MAX        = CNT_MAX_DEF,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   key_filter_pulse_if.slave  key_io
);

   localparam int unsigned    CW       = cnt_width(CNT_MAX);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 32'd1);
   localparam logic           REL_LVL  = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

   key_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          key_pulse_q, key_pulse_d;
   logic          key_state_q, key_state_d;
   logic          key_sync;
   logic          pressed;

   sync_2ff #(.RST_VAL(REL_LVL)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (key_io.key_in),
      .q_o (key_sync)
   );

   assign pressed = (key_sync != REL_LVL);

`ifdef KEY_RELEASE_EN
   logic key_release_q, key_release_d;
`endif

   // Next state, filter counter and registered-output inputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = {CW{1'b0}};
      key_pulse_d = 1'b0;
`ifdef KEY_RELEASE_EN
      key_release_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pressed) begin
               state_d = PRESS_FLT;
            end else begin
               state_d = IDLE;
            end
         end
         PRESS_FLT: begin
            if (!pressed) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = DOWN;
               key_pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DOWN: begin
            if (!pressed) begin
               state_d = REL_FLT;
            end else begin
               state_d = DOWN;
            end
         end
         REL_FLT: begin
            if (pressed) begin
               state_d = DOWN;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
`ifdef KEY_RELEASE_EN
               key_release_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      key_state_d = (state_d == DOWN) || (state_d == REL_FLT);
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CW{1'b0}};
         key_pulse_q <= 1'b0;
         key_state_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_pulse_q <= key_pulse_d;
         key_state_q <= key_state_d;
      end
   end

`ifdef KEY_RELEASE_EN
   // Release pulse register, coincident with key_state falling.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_release_q <= 1'b0;
      end else begin
         key_release_q <= key_release_d;
      end
   end

   assign key_io.key_release = key_release_q;
`else
   assign key_io.key_release = 1'b0;
`endif

   assign key_io.key_pulse = key_pulse_q;
   assign key_io.key_state = key_state_q;

endmodule
